// File: rtl/pll_cfg_sequencer.sv
// pll_cfg_sequencer
//
// Programs the reconfigurable video PLL with a new pixel-clock setting by
// driving the Avalon-MM "mgmt" slave of the pll_reconfig controller. One
// packed M/N/C0/K setting is accepted per handshake. The block issues the
// register-write list, fires the start register, then waits for the PLL to
// re-lock or time out.
//
// Parameters
//   LOCK_BLANK    cycles after the start write during which lock is ignored (>= 1)
//   LOCK_TIMEOUT  cycles allowed for re-lock once blanking has finished
//
// Ports
//   refclk            PLL reference clock, also clocks the mgmt interface
//   rst               synchronous active-high reset
//   cfg_valid/ready   setting handshake; ready is high only while idle
//   cfg_n/m/c0        counter words: [7:0] lo, [15:8] hi, [16] bypass, [17] odd-duty
//   cfg_k, cfg_k_en   M fractional value, written only when cfg_k_en is set
//   cfg_done          one-cycle pulse at the end of a sequence
//   cfg_err           lock-timeout flag, valid with cfg_done, held until next done
//   busy              sequence in progress
//   mgmt_*            Avalon-MM master towards pll_reconfig (waitrequest mode)
//   pll_locked        PLL locked, asynchronous to refclk
module pll_cfg_sequencer #(
  parameter int LOCK_BLANK   = 16,
  parameter int LOCK_TIMEOUT = 1000000
) (
  input  logic        refclk,
  input  logic        rst,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [17:0] cfg_n,
  input  logic [17:0] cfg_m,
  input  logic [17:0] cfg_c0,
  input  logic [31:0] cfg_k,
  input  logic        cfg_k_en,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic        busy,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic [31:0] mgmt_writedata,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked
);

  // Timeout counter never narrower than 20 bits so it cannot wrap before
  // it reaches LOCK_TIMEOUT-1.
  localparam int TO_RAW = $clog2(LOCK_TIMEOUT);
  localparam int TW     = (TO_RAW > 20) ? TO_RAW : 20;
  localparam int BW     = (LOCK_BLANK > 1) ? $clog2(LOCK_BLANK) : 1;

  localparam logic [TW-1:0] TO_LAST    = TW'(LOCK_TIMEOUT - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(LOCK_BLANK - 1);

  // Positions in the write list.
  localparam logic [2:0] IDX_MODE  = 3'd0;
  localparam logic [2:0] IDX_N     = 3'd1;
  localparam logic [2:0] IDX_M     = 3'd2;
  localparam logic [2:0] IDX_C0    = 3'd3;
  localparam logic [2:0] IDX_K     = 3'd4;
  localparam logic [2:0] IDX_START = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_GAP,
    S_BLANK,
    S_WAIT_LOCK,
    S_DONE
  } state_t;

  state_t        state;
  logic [2:0]    widx;
  logic [2:0]    next_idx;
  logic [5:0]    next_addr;
  logic [31:0]   next_data;
  logic [BW-1:0] blank_cnt;
  logic [TW-1:0] to_cnt;

  logic [17:0]   n_q;
  logic [17:0]   m_q;
  logic [17:0]   c0_q;
  logic [31:0]   k_q;
  logic          k_en_q;

  logic          locked_m;
  logic          locked_s;

  // Two-flop synchroniser for the asynchronous PLL lock indication.
  always_ff @(posedge refclk) begin
    if (rst) begin
      locked_m <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      locked_m <= pll_locked;
      locked_s <= locked_m;
    end
  end

  // Next entry of the write list and its bus image. The K write is skipped
  // entirely in integer mode, so C0 is followed directly by start.
  always_comb begin
    next_idx  = widx + 3'd1;
    next_addr = 6'd0;
    next_data = 32'd0;
    if (widx == IDX_C0 && !k_en_q) begin
      next_idx = IDX_START;
    end
    case (next_idx)
      IDX_N: begin
        next_addr = 6'd3;
        next_data = {14'b0, n_q};
      end
      IDX_M: begin
        next_addr = 6'd4;
        next_data = {14'b0, m_q};
      end
      IDX_C0: begin
        next_addr = 6'd5;
        next_data = {9'b0, 5'd0, c0_q};
      end
      IDX_K: begin
        next_addr = 6'd7;
        next_data = k_q;
      end
      IDX_START: begin
        next_addr = 6'd2;
        next_data = 32'd1;
      end
      default: begin
        next_addr = 6'd0;
        next_data = 32'd0;
      end
    endcase
  end

  // Main sequencer. All handshake and bus outputs are registered here; the
  // mode write (address 0, data 0) is launched directly from the accepting
  // edge so the first strobe appears on the following cycle.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state          <= S_IDLE;
      widx           <= IDX_MODE;
      blank_cnt      <= '0;
      to_cnt         <= '0;
      n_q            <= '0;
      m_q            <= '0;
      c0_q           <= '0;
      k_q            <= '0;
      k_en_q         <= 1'b0;
      cfg_ready      <= 1'b0;
      cfg_done       <= 1'b0;
      cfg_err        <= 1'b0;
      busy           <= 1'b0;
      mgmt_write     <= 1'b0;
      mgmt_address   <= '0;
      mgmt_writedata <= '0;
    end else begin
      cfg_done <= 1'b0;
      case (state)
        S_IDLE: begin
          cfg_ready <= 1'b1;
          if (cfg_valid && cfg_ready) begin
            n_q            <= cfg_n;
            m_q            <= cfg_m;
            c0_q           <= cfg_c0;
            k_q            <= cfg_k;
            k_en_q         <= cfg_k_en;
            widx           <= IDX_MODE;
            cfg_ready      <= 1'b0;
            busy           <= 1'b1;
            mgmt_write     <= 1'b1;
            mgmt_address   <= 6'd0;
            mgmt_writedata <= 32'd0;
            state          <= S_WR;
          end
        end

        S_WR: begin
          if (!mgmt_waitrequest) begin
            mgmt_write <= 1'b0;
            if (widx == IDX_START) begin
              blank_cnt <= '0;
              state     <= S_BLANK;
            end else begin
              state <= S_GAP;
            end
          end
        end

        S_GAP: begin
          widx           <= next_idx;
          mgmt_address   <= next_addr;
          mgmt_writedata <= next_data;
          mgmt_write     <= 1'b1;
          state          <= S_WR;
        end

        // Lock may still show the old setting right after start, so it is
        // ignored for LOCK_BLANK cycles.
        S_BLANK: begin
          if (blank_cnt == BLANK_LAST) begin
            to_cnt <= '0;
            state  <= S_WAIT_LOCK;
          end else begin
            blank_cnt <= blank_cnt + BW'(1);
          end
        end

        S_WAIT_LOCK: begin
          if (locked_s) begin
            cfg_done <= 1'b1;
            cfg_err  <= 1'b0;
            state    <= S_DONE;
          end else if (to_cnt == TO_LAST) begin
            cfg_done <= 1'b1;
            cfg_err  <= 1'b1;
            state    <= S_DONE;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end

        S_DONE: begin
          busy      <= 1'b0;
          cfg_ready <= 1'b1;
          state     <= S_IDLE;
        end

        default: begin
          busy      <= 1'b0;
          cfg_ready <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/pll_cfg_sequencer.md
# pll_cfg_sequencer

Programs the Cyclone V reconfigurable video PLL with a new pixel-clock setting. Sits directly upstream of the PLL's reconfiguration controller (Altera pll_reconfig, Avalon-MM "mgmt" slave), which drives the PLL's 64-bit reconfig bus. Accepts one packed M/N/C0/K setting per handshake, issues the register-write sequence, fires the start register, then waits for the PLL to re-lock or time out.

## Interface
- LOCK_BLANK, 16: cycles after the start write during which `pll_locked` is ignored.
- LOCK_TIMEOUT, 1000000: cycles allowed for re-lock after blanking; 20 ms at 50 MHz.
- refclk  in  1  50 MHz PLL reference clock; also clocks the mgmt interface.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  new setting present.
- cfg_ready  out  1  sequencer idle and able to accept a setting.
- cfg_n  in  18  N counter word: [7:0] lo, [15:8] hi, [16] bypass, [17] odd-duty.
- cfg_m  in  18  M counter word, same format.
- cfg_c0  in  18  C0 counter word, same format.
- cfg_k  in  32  M fractional value.
- cfg_k_en  in  1  write K (fractional mode) when 1.
- cfg_done  out  1  one-cycle pulse at end of a sequence.
- cfg_err  out  1  valid with `cfg_done`: 1 = lock timeout.
- busy  out  1  sequence in progress.
- mgmt_address  out  6  reconfig register address.
- mgmt_write  out  1  write strobe.
- mgmt_writedata  out  32  write data.
- mgmt_waitrequest  in  1  slave stall.
- pll_locked  in  1  PLL `locked`, asynchronous to refclk.

## Operation
- `pll_locked` passes through a 2-FF synchroniser. `locked_s` is the second stage.
- The transfer occurs when `cfg_valid && cfg_ready`. All `cfg_*` inputs are captured into internal registers. Later input changes have no effect on the sequence.
- The FSM states are IDLE, WR, GAP, BLANK, WAIT_LOCK, DONE.
- IDLE: `cfg_ready`=1 and `busy`=0. A transfer moves the FSM to WR with write index 0.
- The write list runs in order:
  - addr 0 data 0 (mode = waitrequest mode).
  - addr 3 data {14'b0,n}.
  - addr 4 data {14'b0,m}.
  - addr 5 data {9'b0,5'd0,c0}: counter select [22:18]=0.
  - addr 7 data k, only when `cfg_k_en`=1; otherwise skipped with no bus cycle.
  - addr 2 data 1 (start).
- WR: `mgmt_write`=1 with address and data stable. The write completes on the first edge where `mgmt_waitrequest`=0. The FSM then moves to GAP, or to BLANK after the start write.
- GAP: exactly one cycle with `mgmt_write`=0, then WR with the next index.
- BLANK: counts LOCK_BLANK cycles, then moves to WAIT_LOCK with the timeout counter cleared.
- WAIT_LOCK: `locked_s`=1 moves to DONE with err=0. If the counter reaches LOCK_TIMEOUT-1 without lock, the FSM moves to DONE with err=1.
- DONE: `cfg_done`=1 for one cycle and `cfg_err` is valid. The FSM then returns to IDLE.
- `busy`=1 in every state except IDLE.
- `cfg_err` holds its value until the next DONE.
- No bus timeout exists: a slave that stalls forever also stalls the sequencer. `rst` is the only recovery.

## Timing
- While `rst`=1 and on the cycle after it deasserts, all outputs are 0: `cfg_ready`, `busy`, `cfg_done`, `cfg_err`, `mgmt_write`, `mgmt_address`, `mgmt_writedata`. The FSM is in IDLE and the counters are cleared. `cfg_ready` rises on the first edge after reset is released.
- Asserting `rst` mid-sequence drops `mgmt_write` at the next edge and returns the FSM to IDLE. No `cfg_done` is issued. The top level resets pll_reconfig on the same `rst`.
- The first `mgmt_write` is asserted on the cycle after the accepting edge.
- Each write takes 1 + W cycles, where W is the number of waitrequest stall cycles. Each write is followed by a 1-cycle GAP; the start write has no GAP.
- With waitrequest held at 0:
  - 5 writes (K skipped) span 9 cycles from first strobe to last strobe.
  - 6 writes span 11 cycles.
- `cfg_done` occurs no sooner than LOCK_BLANK+1 cycles after the start write completes.
- `cfg_valid` asserted during `busy` is not accepted; `cfg_ready`=0 throughout.
- Timeout arithmetic: the counter is 20 bits minimum, sized from LOCK_TIMEOUT, and must not wrap before it compares equal.

## Test plan
- Zero wait, K disabled. Send n=0x20202, m=0x21B1A, c0=0x00404. Required:
  - Writes at addresses 0,3,4,5,2, each strobe 1 cycle with a 1-cycle gap.
  - Data 0, 0x20202, 0x21B1A, 0x00404, 1.
  - With locked rising 30 cycles after start: `cfg_done` pulses with err=0.
- K enabled, k=0x80000000. Required: address 7 with data 0x80000000 appears between addresses 5 and 2, and there are 6 strobes in total.
- Waitrequest held high 3 cycles on the address 4 write. Required:
  - `mgmt_write`, address and data held stable for 4 cycles.
  - The sequence continues in order with no dropped or duplicated write.
- LOCK_TIMEOUT=100, locked held at 0. Required:
  - `cfg_done`=1 with `cfg_err`=1 exactly 100 cycles after BLANK ends.
  - `cfg_ready` returns to 1 on the next cycle.
- Locked stays 1 through the start write (no drop). Required: no `cfg_done` during BLANK; done arrives LOCK_BLANK+1 cycles after the start write completes.
- `rst` pulsed during the address 4 write. Required:
  - `mgmt_write`=0 next cycle, with no done pulse.
  - A new setting accepted after reset runs the full sequence from address 0.
